// File: rtl/flag_array_ctrl.sv
// Flag plane controller for the minesweeper board: toggles per-field flags through a
// req/ack handshake, tracks total/correct flag counts, detects the win and sweeps the plane on new game.
module flag_array_ctrl #(
    parameter int MAX_DIM    = 16,
    parameter int DIM_EASY   = 8,
    parameter int DIM_MEDIUM = 10,
    parameter int DIM_HARD   = 16,
    parameter int IDX_W      = 5,
    parameter int CNT_W      = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   level,
    input  logic                         new_game,
    input  logic                         flag_req,
    input  logic [IDX_W-1:0]             flag_x,
    input  logic [IDX_W-1:0]             flag_y,
    input  logic [MAX_DIM*MAX_DIM-1:0]   mine_arr,
    input  logic [CNT_W-1:0]             mine_total,
    output logic                         flag_ack,
    output logic                         flag_rej,
    output logic                         busy,
    output logic [MAX_DIM*MAX_DIM-1:0]   flag_arr,
    output logic [CNT_W-1:0]             flag_cnt,
    output logic [CNT_W-1:0]             flags_left,
    output logic                         all_defused,
    input  logic [IDX_W-1:0]             rd_x,
    input  logic [IDX_W-1:0]             rd_y,
    output logic                         rd_flag
);
    localparam int NB    = MAX_DIM * MAX_DIM;
    localparam int BIT_W = $clog2(NB);
    localparam int ROW_W = $clog2(MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_APPLY = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         level_q, level_d;
    logic [IDX_W-1:0]   x_q, x_d, y_q, y_d;
    logic [BIT_W-1:0]   idx_q, idx_d;
    logic               mine_q, mine_d, set_q, set_d;
    logic               ack_q, ack_d, rej_q, rej_d;
    logic [NB-1:0]      flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, corr_q, corr_d;
    logic               alld_q, alld_d, rd_q, rd_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   dim_s;
    logic [BIT_W-1:0]   chk_idx_s, row_base_s;
    logic               chk_ok_s;

    function automatic logic in_range(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y,
                                      input logic [IDX_W-1:0] d);
        return (x != {IDX_W{1'b0}}) && (y != {IDX_W{1'b0}}) && (x <= d) && (y <= d);
    endfunction

    function automatic logic [BIT_W-1:0] bit_idx(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y);
        int lin;
        lin = (int'(y) - 1) * MAX_DIM + (int'(x) - 1);
        return BIT_W'(lin);
    endfunction

    // Board edge from the level latched at the last new game
    always_comb begin
        case (level_q)
            2'd1:    dim_s = IDX_W'(DIM_EASY);
            2'd2:    dim_s = IDX_W'(DIM_MEDIUM);
            2'd3:    dim_s = IDX_W'(DIM_HARD);
            default: dim_s = {IDX_W{1'b0}};
        endcase
    end

    // Setting needs headroom below mine_total; removing an existing flag is always allowed
    assign chk_idx_s  = bit_idx(x_q, y_q);
    assign chk_ok_s   = in_range(x_q, y_q, dim_s) && (flag_q[chk_idx_s] || (cnt_q < mine_total));
    assign row_base_s = BIT_W'(int'(row_q) * MAX_DIM);

    // Next-state logic; new_game overrides everything else
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = flag_req ? ST_CHECK : ST_IDLE;
            ST_CHECK: state_d = ST_APPLY;
            ST_APPLY: state_d = ST_IDLE;
            ST_CLEAR: state_d = (row_q == ROW_W'(MAX_DIM - 1)) ? ST_IDLE : ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
        if (new_game) begin
            state_d = ST_CLEAR;
        end else begin
            state_d = state_d;
        end
    end

    // Datapath next-state: capture, decide, apply, sweep
    always_comb begin
        level_d = level_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        mine_d  = mine_q;
        set_d   = set_q;
        ack_d   = 1'b0;
        rej_d   = 1'b0;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        corr_d  = corr_q;
        row_d   = row_q;
        if (new_game) begin
            level_d = level;
            cnt_d   = {CNT_W{1'b0}};
            corr_d  = {CNT_W{1'b0}};
            row_d   = {ROW_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flag_req) begin
                        x_d = flag_x;
                        y_d = flag_y;
                    end else begin
                        x_d = x_q;
                    end
                end
                ST_CHECK: begin
                    ack_d  = chk_ok_s;
                    rej_d  = ~chk_ok_s;
                    idx_d  = chk_idx_s;
                    mine_d = mine_arr[chk_idx_s];
                    set_d  = ~flag_q[chk_idx_s];
                end
                ST_APPLY: begin
                    if (ack_q && set_q) begin
                        flag_d[idx_q] = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        corr_d = corr_q + CNT_W'(mine_q);
                    end else if (ack_q) begin
                        flag_d[idx_q] = 1'b0;
                        cnt_d  = (cnt_q != {CNT_W{1'b0}}) ? cnt_q - CNT_W'(1) : cnt_q;
                        corr_d = (mine_q && (corr_q != {CNT_W{1'b0}})) ? corr_q - CNT_W'(1) : corr_q;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_CLEAR: begin
                    flag_d[row_base_s +: MAX_DIM] = {MAX_DIM{1'b0}};
                    row_d = row_q + ROW_W'(1);
                end
                default: row_d = row_q;
            endcase
        end
        alld_d = ~new_game && (mine_total != {CNT_W{1'b0}}) && (cnt_q == mine_total) && (corr_q == mine_total);
        rd_d   = in_range(rd_x, rd_y, dim_s) ? flag_q[bit_idx(rd_x, rd_y)] : 1'b0;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            level_q <= 2'd0;
            x_q     <= {IDX_W{1'b0}};
            y_q     <= {IDX_W{1'b0}};
            idx_q   <= {BIT_W{1'b0}};
            mine_q  <= 1'b0;
            set_q   <= 1'b0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            flag_q  <= {NB{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            corr_q  <= {CNT_W{1'b0}};
            alld_q  <= 1'b0;
            rd_q    <= 1'b0;
            row_q   <= {ROW_W{1'b0}};
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            mine_q  <= mine_d;
            set_q   <= set_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            corr_q  <= corr_d;
            alld_q  <= alld_d;
            rd_q    <= rd_d;
            row_q   <= row_d;
        end
    end

    assign flag_ack    = ack_q;
    assign flag_rej    = rej_q;
    assign busy        = (state_q != ST_IDLE);
    assign flag_arr    = flag_q;
    assign flag_cnt    = cnt_q;
    assign all_defused = alld_q;
    assign rd_flag     = rd_q;
    assign flags_left  = (mine_total > cnt_q) ? (mine_total - cnt_q) : {CNT_W{1'b0}};
endmodule
